// File: rtl/generic_mem_pkg.sv
// Shared types and helpers for generic_mem_be: FSM state encoding, latency limit
// and the byte-merge function used by both the array write and the read bypass.
package generic_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int MAX_RD_LATENCY = 4;

  // be_merge works on a fixed wide word; callers zero-extend in and truncate out.
  localparam int MAX_WIDTH = 512;
  localparam int MAX_BEW   = MAX_WIDTH / 8;

  function automatic logic [MAX_WIDTH-1:0] be_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BEW-1:0]   be
  );
    logic [MAX_WIDTH-1:0] merged;
    for (int i = 0; i < MAX_BEW; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/generic_mem_rd_pipe.sv
// Read-side delay line: STAGES registers of valid + data, flushed by reset.
// Data of a stage only moves when the stage feeding it is valid, so the tail holds.
module generic_mem_rd_pipe
  import generic_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             vld_out,
  output logic [WIDTH-1:0] data_out
);

  logic             vld_p  [STAGES];
  logic [WIDTH-1:0] data_p [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= vld_in;
      if (vld_in) data_p[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign vld_out  = vld_p[STAGES-1];
  assign data_out = data_p[STAGES-1];

endmodule

// File: rtl/generic_mem_be.sv
// Single-clock RAM with byte enables, RD_LATENCY-cycle reads and a post-reset clear sweep.
// Define GENERIC_MEM_RD_BYPASS_EN for write-first same-address reads (read-first otherwise).
module generic_mem_be
  import generic_mem_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int WIDTH      = 32,
  parameter  int RD_LATENCY = 1,
  localparam int AWIDTH     = $clog2(DEPTH),
  localparam int BEW        = WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_wr_en,
  input  logic [AWIDTH-1:0] mem_wr_addr,
  input  logic [WIDTH-1:0]  mem_wr_data,
  input  logic [BEW-1:0]    mem_wr_be,
  input  logic              mem_rd_en,
  input  logic [AWIDTH-1:0] mem_rd_addr,
  output logic [WIDTH-1:0]  mem_rd_data,
  output logic              mem_rd_valid,
  output logic              mem_init_busy
);

  localparam int                PIPE_STAGES = ((RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY) - 1;
  localparam logic [AWIDTH:0]   DEPTH_W     = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR   = AWIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state;
  logic [AWIDTH-1:0] clr_ptr;

  logic             wr_ok;
  logic             rd_ok;
  logic             rd_in_range;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;

  assign wr_ok       = (state == ST_READY) && mem_wr_en && ({1'b0, mem_wr_addr} < DEPTH_W);
  assign rd_ok       = (state == ST_READY) && mem_rd_en;
  assign rd_in_range = {1'b0, mem_rd_addr} < DEPTH_W;

  always_comb begin
    wr_word = WIDTH'(be_merge(MAX_WIDTH'(mem[mem_wr_addr]), MAX_WIDTH'(mem_wr_data),
                              MAX_BEW'(mem_wr_be)));
`ifdef GENERIC_MEM_RD_BYPASS_EN
    rd_word = (wr_ok && (mem_wr_addr == mem_rd_addr)) ? wr_word : mem[mem_rd_addr];
`else
    rd_word = mem[mem_rd_addr];
`endif
    if (!rd_in_range) rd_word = '0;
  end

  // Clear sweep: one word per cycle, READY once the last address has been zeroed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_INIT;
      clr_ptr       <= '0;
      mem_init_busy <= 1'b1;
    end else if (state == ST_INIT) begin
      if (clr_ptr == LAST_ADDR) begin
        state         <= ST_READY;
        mem_init_busy <= 1'b0;
      end else begin
        clr_ptr <= clr_ptr + AWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) mem[clr_ptr] <= '0;
      else if (wr_ok)       mem[mem_wr_addr] <= wr_word;
    end
  end

  // Stage p0: array read register (the output itself when RD_LATENCY is 1).
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_ok;
      if (rd_ok) data_p0 <= rd_word;
    end
  end

  // Stages p1..: extra latency beyond the array read.
  generate
    if (PIPE_STAGES == 0) begin : g_no_pipe
      assign mem_rd_valid = vld_p0;
      assign mem_rd_data  = data_p0;
    end else begin : g_pipe
      generic_mem_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (PIPE_STAGES)
      ) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .vld_in   (vld_p0),
        .data_in  (data_p0),
        .vld_out  (mem_rd_valid),
        .data_out (mem_rd_data)
      );
    end
  endgenerate

endmodule

// File: tb/tb_generic_mem_be.sv
// Bench for generic_mem_be: two instances (DEPTH=16/RD_LATENCY=3 and DEPTH=12/RD_LATENCY=1)
// share one stimulus stream and are compared with a per-instance memory + read-queue model.
module tb_generic_mem_be;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  generic_mem_be #(.DEPTH(16), .WIDTH(32), .RD_LATENCY(3)) u_dut_a (
    .clk(clk), .reset(reset), .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
    .mem_wr_be(wr_be), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data_a),
    .mem_rd_valid(rd_valid_a), .mem_init_busy(busy_a));

  generic_mem_be #(.DEPTH(12), .WIDTH(32), .RD_LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset), .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
    .mem_wr_be(wr_be), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data_b),
    .mem_rd_valid(rd_valid_b), .mem_init_busy(busy_b));

  logic        ov [2];
  logic        ob [2];
  logic [31:0] od [2];
  assign ov[0] = rd_valid_a;  assign ov[1] = rd_valid_b;
  assign ob[0] = busy_a;      assign ob[1] = busy_b;
  assign od[0] = rd_data_a;   assign od[1] = rd_data_b;

  // Reference model: word array, remaining clear cycles, and reads awaiting their due cycle.
  int          depth_of [2] = '{16, 12};
  int          lat_of   [2] = '{3, 1};
  logic [31:0] mdl [2][16];
  int          init_left [2];
  logic        ev [2];
  logic        eb [2];
  logic [31:0] ed [2];
  int          cyc;
  bit          bypass_en;
  int          errors, checks;

  typedef struct {
    int          k;
    int          due;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0] v;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int a = 0; a < 16; a++) mdl[k][a] = '0;
        init_left[k] = depth_of[k];
        ev[k] = 1'b0;
        ed[k] = '0;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
      end else begin
        if (init_left[k] > 0) begin
          init_left[k]--;
        end else begin
          if (rd_en) begin
            if (int'(rd_addr) >= depth_of[k]) v = '0;
            else if (bypass_en && wr_en && wr_addr == rd_addr) v = merge(mdl[k][rd_addr], wr_data, wr_be);
            else v = mdl[k][rd_addr];
            q.push_back('{k, cyc + lat_of[k] - 1, v});
          end
          if (wr_en && int'(wr_addr) < depth_of[k]) mdl[k][wr_addr] = merge(mdl[k][wr_addr], wr_data, wr_be);
        end
        ev[k] = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].k == k && q[i].due == cyc) begin
            ev[k] = 1'b1;
            ed[k] = q[i].d;
            q.delete(i);
            break;
          end
        end
      end
      eb[k] = (init_left[k] > 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int cnt_a, cnt_b;
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_addr = 4'd3; rd_addr = 4'd3;
    wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ov[k] !== 1'b0 || od[k] !== 32'h0 || ob[k] !== 1'b1) begin
          errors++;
          $display("FAIL reset_state dut%0d: v=%b d=%h busy=%b, want v=0 d=0 busy=1", k, ov[k], od[k], ob[k]);
        end
      end
    end
    reset = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (ob[0]) cnt_a++;
      if (ob[1]) cnt_b++;
      if (i == 10) idle();
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ov[k] !== ev[k] || od[k] !== ed[k] || ob[k] !== eb[k]) begin
          errors++;
          $display("FAIL init_sweep dut%0d cyc%0d: v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   k, cyc, ov[k], od[k], ob[k], ev[k], ed[k], eb[k]);
        end
      end
    end
    checks++;
    if (cnt_a !== 16) begin errors++; $display("FAIL busy_len_a: got %0d cycles, want 16", cnt_a); end
    checks++;
    if (cnt_b !== 12) begin errors++; $display("FAIL busy_len_b: got %0d cycles, want 12", cnt_b); end
  endtask

  task automatic test_clear_readback(input string name);
    int nva;
    nva = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) begin rd_en = 1'b1; rd_addr = 4'(i); end
      else idle();
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ov[k] !== ev[k] || od[k] !== ed[k] || ob[k] !== eb[k]) begin
          errors++;
          $display("FAIL %s dut%0d cyc%0d: v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   name, k, cyc, ov[k], od[k], ob[k], ev[k], ed[k], eb[k]);
        end
      end
      if (ov[0]) begin
        nva++;
        checks++;
        if (od[0] !== 32'h0) begin errors++; $display("FAIL %s_zero: got %h, want 00000000", name, od[0]); end
      end
    end
    checks++;
    if (nva !== 16) begin errors++; $display("FAIL %s_count: got %0d valids, want 16", name, nva); end
  endtask

  task automatic test_byte_enable();
    bit seen;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF; tick();
    wr_data = 32'h1122_3344; wr_be = 4'b0101; tick();
    idle(); rd_en = 1'b1; rd_addr = 4'd5; tick();
    idle();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (ov[0]) begin
        seen = 1'b1;
        checks++;
        if (od[0] !== 32'hDE22_BE44) begin errors++; $display("FAIL byte_enable: got %h, want DE22BE44", od[0]); end
      end else tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL byte_enable_timeout: got no valid, want one"); end
  endtask

  task automatic test_pipelined_reads();
    logic [31:0] vals [4];
    int          hit_t [$];
    logic [31:0] hit_d [$];
    for (int a = 1; a <= 3; a++) begin
      vals[a] = $urandom();
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = vals[a]; wr_be = 4'hF; tick();
    end
    idle();
    for (int t = 1; t <= 8; t++) begin
      if (t <= 3) begin rd_en = 1'b1; rd_addr = 4'(t); end
      else idle();
      tick();
      if (ov[0]) begin hit_t.push_back(t); hit_d.push_back(od[0]); end
    end
    checks++;
    if (hit_t.size() !== 3) begin
      errors++; $display("FAIL pipe_count: got %0d valids, want 3", hit_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hit_t[i] !== i + 3 || hit_d[i] !== vals[i+1]) begin
          errors++;
          $display("FAIL pipe_read%0d: got cycle %0d data %h, want cycle %0d data %h",
                   i, hit_t[i], hit_d[i], i + 3, vals[i+1]);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    logic [31:0] got [$];
    want = bypass_en ? 32'hAAAA_AAAA : 32'h0;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hAAAA_AAAA; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd7; tick();
    wr_en = 1'b0; tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      if (ov[0]) got.push_back(od[0]);
      tick();
    end
    checks++;
    if (got.size() !== 2) begin
      errors++; $display("FAIL same_cycle_count: got %0d valids, want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== want) begin errors++; $display("FAIL same_cycle_rw: got %h, want %h", got[0], want); end
      checks++;
      if (got[1] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL read_after_write: got %h, want AAAAAAAA", got[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int nv, cnt_a;
    for (int a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = $urandom() | 32'h1; wr_be = 4'hF; tick();
    end
    idle(); rd_en = 1'b1; rd_addr = 4'd4; tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 9; i++) begin tick(); if (ov[0] || ov[1]) nv++; end
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 24; i++) begin
      if (ob[0]) cnt_a++;
      tick();
      if (ov[0] || ov[1]) nv++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ov[k] !== ev[k] || od[k] !== ed[k] || ob[k] !== eb[k]) begin
          errors++;
          $display("FAIL reset_mid dut%0d cyc%0d: v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   k, cyc, ov[k], od[k], ob[k], ev[k], ed[k], eb[k]);
        end
      end
    end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL reset_flush: got %0d valids, want 0", nv); end
    checks++;
    if (cnt_a !== 16) begin errors++; $display("FAIL reset_busy_len: got %0d cycles, want 16", cnt_a); end
    test_clear_readback("reset_clear");
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hCAFE_F00D; wr_be = 4'hF; tick();
    idle(); rd_en = 1'b1; rd_addr = 4'd13; tick();
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 32'h0) begin
      errors++; $display("FAIL oob_read: got v=%b d=%h, want v=1 d=00000000", ov[1], od[1]);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin rd_en = 1'b1; rd_addr = 4'(i); end
      else idle();
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ov[k] !== ev[k] || od[k] !== ed[k]) begin
          errors++;
          $display("FAIL oob_untouched dut%0d cyc%0d: v=%b d=%h, want v=%b d=%h", k, cyc, ov[k], od[k], ev[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      rd_en   = ($urandom_range(0, 2) != 0);
      wr_addr = 4'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      wr_be   = 4'($urandom_range(0, 15));
      wr_data = $urandom();
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ov[k] !== ev[k] || od[k] !== ed[k] || ob[k] !== eb[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   k, cyc, ov[k], od[k], ob[k], ev[k], ed[k], eb[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
`ifdef GENERIC_MEM_RD_BYPASS_EN
    bypass_en = 1'b1;
`else
    bypass_en = 1'b0;
`endif
    test_reset();
    test_clear_readback("clear_readback");
    test_same_cycle();
    test_byte_enable();
    test_pipelined_reads();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/generic_mem_be.md
Name: generic_mem_be

Overview:
Parametrised single-clock memory: one write port, one read port.
- Successor of the basic registered-read memory, adding per-byte write enables, configurable read latency with a valid strobe, and a post-reset hardware clear sequencer.
- Used as the register-file / RAM building block in SAP-class datapaths where memory contents must be deterministic after reset.

Parameters:
DEPTH, 16, number of words (any value >= 2; need not be a power of two)
WIDTH, 32, word width in bits (must be a multiple of 8)
RD_LATENCY, 1, cycles from mem_rd_en to mem_rd_valid (legal 1..4)
AWIDTH, $clog2(DEPTH), localparam, address width
BEW, WIDTH/8, localparam, byte-enable width

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
mem_wr_en  in  1  write request
mem_wr_addr  in  AWIDTH  write address
mem_wr_data  in  WIDTH  write data
mem_wr_be  in  BEW  byte enables; bit i covers bits [8i+7:8i]
mem_rd_en  in  1  read request
mem_rd_addr  in  AWIDTH  read address
mem_rd_data  out  WIDTH  read data, valid when mem_rd_valid=1
mem_rd_valid  out  1  one-cycle strobe per accepted read
mem_init_busy  out  1  clear sequence in progress; requests ignored

Behaviour:
- Reset values: mem_rd_data=0, mem_rd_valid=0, mem_init_busy=1, clear pointer=0, read pipeline flushed.
- FSM states: INIT, READY.
  - Reset forces INIT.
  - In INIT, one word per cycle (address = clear pointer) is written to all-zero; the pointer increments.
  - No clear writes while reset=1.
  - INIT -> READY in the cycle after address DEPTH-1 is cleared.
  - mem_init_busy is therefore high for exactly DEPTH cycles after reset deasserts.
- In INIT, mem_wr_en and mem_rd_en are ignored: no write, no mem_rd_valid.
- Reset mid-sweep or mid-read restarts the sweep from 0 and drops in-flight reads (no valid emitted).
- Write (READY, mem_wr_en=1): only bytes with mem_wr_be[i]=1 are updated at the clock edge. be=0 with wr_en=1 is a no-op.
- Read (READY, mem_rd_en=1 at edge N):
  - mem_rd_valid=1 and mem_rd_data updated after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request.
  - RD_LATENCY=1 is identical to a plain registered read.
  - Back-to-back reads are fully pipelined, one per cycle.
  - mem_rd_data holds its last value while mem_rd_valid=0.
- Address >= DEPTH (non-power-of-two DEPTH): write ignored; read returns 0 with valid asserted.
- Same-address write and read in the same cycle: see Optional Feature.
- Read of the address written in the previous cycle always returns the new data.

Optional Feature:
- Macro GENERIC_MEM_RD_BYPASS_EN.
- Defined (write-first): a same-cycle, same-address read returns merged data: enabled bytes from mem_wr_data, others from the array.
- Undefined (read-first): the read returns the pre-write array contents; no bypass mux is built.

Decomposition:
- Package generic_mem_pkg:
  - state encoding (ST_INIT, ST_READY)
  - constant MAX_RD_LATENCY=4
  - function be_merge(old, new, be) returning the byte-merged word, shared by array write and bypass
- Sub-module generic_mem_rd_pipe: valid/data delay line of RD_LATENCY-1 stages with synchronous flush on reset.

Test Plan:
- DEPTH=16, hold reset 3 cycles, release -> mem_init_busy high exactly 16 cycles; then read all 16 addresses -> every word 0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101 -> read addr 5 returns 0xDE22BE44.
- RD_LATENCY=3, reads of addr 1,2,3 on consecutive cycles -> mem_rd_valid high on 3 consecutive cycles starting 3 cycles after the first request, with data in order.
- Same cycle: write 0xAAAAAAAA to addr 7, read addr 7, old value 0 -> returns 0xAAAAAAAA with macro defined, 0x00000000 without.
- Assert reset at sweep pointer 9 with a read in flight -> no mem_rd_valid; busy stays high 16 cycles after release; memory all zero.
- DEPTH=12: write addr 13 then read addr 13 -> data 0, valid asserted; addr 0..11 unchanged.
